mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between instruction fetch (requester 0) and data load/store (requester 1).

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/mem_align_check.sv | 26 ++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: size codes,
// requester IDs and the arbiter state encoding.
package cpu_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check for one memory access; fetches are always
// word accesses, and the reserved size code counts as misaligned.
module mem_align_check
   import cpu_mem_pkg::*;
(
   input  logic [1:0] addr_lo,
   input  logic [1:0] size,
   input  logic       is_fetch,
   output logic       misaligned
);

   always_comb begin
      misaligned = 1'b0;
      if (is_fetch) begin
         misaligned = (addr_lo != 2'b00);
      end else begin
         case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-port memory,
// one command at a time, with alignment checking, timeout and one-cycle acks.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15,
   parameter int RR      = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   output logic          if_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          d_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [1:0]    mem_size,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          busy,
   output logic          last_grant
);

   localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   arb_state_t    state_q, state_d;
   logic          any_req;
   logic          grant_id;
   logic          grant_fetch;
   logic [AW-1:0] sel_addr;
   logic [1:0]    sel_size;
   logic          sel_misaligned;
   logic          timeout_hit;
   logic [CW-1:0] cnt_q, cnt_inc;

   logic          win_q;
   logic          last_grant_q;
   logic          err_q;
   logic          cmd_we_q;
   logic [1:0]    cmd_size_q;
   logic [AW-1:0] cmd_addr_q;
   logic [DW-1:0] cmd_wdata_q;
   logic [DW-1:0] if_rdata_q;
   logic [DW-1:0] d_rdata_q;

   // On a tie, round-robin favours whoever did not win last time.
   always_comb begin
      any_req  = if_req | d_req;
      grant_id = REQ_D;
      if (if_req && d_req) begin
         grant_id = (RR != 0) ? ~last_grant_q : REQ_D;
      end else if (if_req) begin
         grant_id = REQ_IF;
      end
      grant_fetch = (grant_id == REQ_IF);
      sel_addr    = grant_fetch ? if_addr : d_addr;
      sel_size    = grant_fetch ? SZ_WORD : d_size;
   end

   mem_align_check u_align (
      .addr_lo    (sel_addr[1:0]),
      .size       (sel_size),
      .is_fetch   (grant_fetch),
      .misaligned (sel_misaligned)
   );

   assign cnt_inc     = cnt_q + 1'b1;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:  if (any_req) state_d = sel_misaligned ? ARB_RESP : ARB_ISSUE;
         ARB_ISSUE: state_d = ARB_WAIT;
         ARB_WAIT:  if (mem_ready || timeout_hit) state_d = ARB_RESP;
         ARB_RESP:  state_d = ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ARB_IDLE;
      else       state_q <= state_d;
   end

   // Command, counter and read-data registers; everything clears on reset so
   // that every output reads zero while the arbiter is held in reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_q        <= REQ_IF;
         last_grant_q <= REQ_IF;
         err_q        <= 1'b0;
         cmd_we_q     <= 1'b0;
         cmd_size_q   <= 2'b00;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (any_req) begin
                  win_q        <= grant_id;
                  last_grant_q <= grant_id;
                  err_q        <= sel_misaligned;
                  cmd_we_q     <= grant_fetch ? 1'b0 : d_we;
                  cmd_size_q   <= sel_size;
                  cmd_addr_q   <= sel_addr;
                  cmd_wdata_q  <= grant_fetch ? '0 : d_wdata;
                  cnt_q        <= '0;
               end
            end
            ARB_WAIT: begin
               if (mem_ready) begin
                  err_q <= 1'b0;
                  if (!cmd_we_q) begin
                     if (win_q == REQ_IF) if_rdata_q <= mem_rdata;
                     else                 d_rdata_q  <= mem_rdata;
                  end
               end else begin
                  if (cnt_q != CNT_MAX) cnt_q <= cnt_inc;
                  if (timeout_hit)      err_q <= 1'b1;
               end
            end
            ARB_RESP: cnt_q <= '0;
            default: ;
         endcase
      end
   end

   assign mem_en     = (state_q == ARB_ISSUE);
   assign mem_we     = mem_en & cmd_we_q;
   assign mem_size   = cmd_size_q;
   assign mem_addr   = cmd_addr_q;
   assign mem_wdata  = cmd_wdata_q;

   assign if_ack     = (state_q == ARB_RESP) && (win_q == REQ_IF);
   assign d_ack      = (state_q == ARB_RESP) && (win_q == REQ_D);
   assign if_err     = if_ack & err_q;
   assign d_err      = d_ack & err_q;
   assign if_rdata   = if_rdata_q;
   assign d_rdata    = d_rdata_q;

   assign busy       = (state_q != ARB_IDLE);
   assign last_grant = last_grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two instances (fixed priority and
// round-robin) checked against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int TO = 15;

   logic        clk, reset;
   logic        if_req[2];
   logic [31:0] if_addr[2];
   logic        if_ack[2];
   logic [31:0] if_rdata[2];
   logic        if_err[2];
   logic        d_req[2], d_we[2];
   logic [1:0]  d_size[2];
   logic [31:0] d_addr[2], d_wdata[2];
   logic        d_ack[2];
   logic [31:0] d_rdata[2];
   logic        d_err[2];
   logic        mem_en[2], mem_we[2];
   logic [1:0]  mem_size[2];
   logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
   logic        mem_ready[2];
   logic        busy[2], last_grant[2];

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: last grant and the two read-data registers per instance.
   bit          lg_m[2];
   logic [31:0] ifr_m[2], dr_m[2];

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO), .RR(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]),
      .if_rdata(if_rdata[0]), .if_err(if_err[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_size(d_size[0]), .d_addr(d_addr[0]),
      .d_wdata(d_wdata[0]), .d_ack(d_ack[0]), .d_rdata(d_rdata[0]), .d_err(d_err[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_size(mem_size[0]),
      .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
      .mem_ready(mem_ready[0]), .busy(busy[0]), .last_grant(last_grant[0])
   );

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO), .RR(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]),
      .if_rdata(if_rdata[1]), .if_err(if_err[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_size(d_size[1]), .d_addr(d_addr[1]),
      .d_wdata(d_wdata[1]), .d_ack(d_ack[1]), .d_rdata(d_rdata[1]), .d_err(d_err[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_size(mem_size[1]),
      .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
      .mem_ready(mem_ready[1]), .busy(busy[1]), .last_grant(last_grant[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      return a;
   endfunction

   task automatic new_if(input int u);
      if_req[u]  = 1'b1;
      if_addr[u] = rand_addr();
   endtask

   task automatic new_d(input int u);
      d_req[u]   = 1'b1;
      d_we[u]    = 1'($urandom_range(0, 1));
      d_size[u]  = 2'($urandom_range(0, 3));
      d_addr[u]  = rand_addr();
      d_wdata[u] = $urandom;
   endtask

   task automatic clear_inputs();
      for (int u = 0; u < 2; u++) begin
         if_req[u] = 0; if_addr[u] = 0; d_req[u] = 0; d_we[u] = 0; d_size[u] = 0;
         d_addr[u] = 0; d_wdata[u] = 0; mem_rdata[u] = 0; mem_ready[u] = 0;
         lg_m[u] = 0; ifr_m[u] = 0; dr_m[u] = 0;
      end
   endtask

   // One transaction starting at a negedge with the instance idle. lat is the
   // number of non-ready WAIT cycles before mem_ready (random when negative).
   task automatic run_txn(input int u, input int lat_in, input bit fresh,
                          input bit use_fix, input logic [31:0] rd_fix);
      bit          win, mis, err;
      int          lat, a_idx;
      logic [31:0] exp_addr, rd, rd_cap;
      logic [1:0]  exp_size;
      bit          exp_we, exp_en;
      if (fresh) begin
         if (!if_req[u] && $urandom_range(0, 1) == 1) new_if(u);
         if (!d_req[u] && $urandom_range(0, 1) == 1) new_d(u);
         if (!if_req[u] && !d_req[u]) begin
            if ($urandom_range(0, 1) == 1) new_if(u);
            else new_d(u);
         end
      end
      if (if_req[u] && d_req[u]) win = (u == 1) ? !lg_m[u] : 1'b1;
      else                       win = d_req[u];
      if (!win) mis = (if_addr[u] % 4) != 0;
      else begin
         case (d_size[u])
            2'd0:    mis = 0;
            2'd1:    mis = (d_addr[u] % 2) != 0;
            2'd2:    mis = (d_addr[u] % 4) != 0;
            default: mis = 1;
         endcase
      end
      if (lat_in >= 0) lat = lat_in;
      else if ($urandom_range(0, 4) == 0) lat = $urandom_range(12, 18);
      else lat = $urandom_range(0, 4);
      err      = mis || (lat >= TO);
      a_idx    = mis ? 1 : ((lat < TO) ? 3 + lat : 2 + TO);
      exp_addr = win ? d_addr[u] : if_addr[u];
      exp_size = win ? d_size[u] : 2'b10;
      exp_we   = win && d_we[u];
      lg_m[u]  = win;
      rd_cap   = 0;
      mem_ready[u] = 1'($urandom_range(0, 1));
      mem_rdata[u] = $urandom;
      for (int i = 1; i <= a_idx; i++) begin
         @(negedge clk);
         exp_en = (i == 1) && !mis;
         chk("mem_en", 32'(mem_en[u]), 32'(exp_en));
         if (exp_en) begin
            chk("mem_addr", mem_addr[u], exp_addr);
            chk("mem_size", 32'(mem_size[u]), 32'(exp_size));
            chk("mem_we", 32'(mem_we[u]), 32'(exp_we));
            if (exp_we) chk("mem_wdata", mem_wdata[u], d_wdata[u]);
         end
         chk("busy", 32'(busy[u]), 32'd1);
         chk("last_grant", 32'(last_grant[u]), 32'(lg_m[u]));
         chk("if_ack", 32'(if_ack[u]), 32'((i == a_idx) && !win));
         chk("d_ack", 32'(d_ack[u]), 32'((i == a_idx) && win));
         if (i == a_idx) begin
            if (!err && !exp_we) begin
               if (win) dr_m[u] = rd_cap;
               else     ifr_m[u] = rd_cap;
            end
            chk("if_err", 32'(if_err[u]), 32'(!win && err));
            chk("d_err", 32'(d_err[u]), 32'(win && err));
            chk("if_rdata", if_rdata[u], ifr_m[u]);
            chk("d_rdata", d_rdata[u], dr_m[u]);
            if (win) d_req[u] = 0;
            else     if_req[u] = 0;
         end
         rd = use_fix ? rd_fix : $urandom;
         mem_rdata[u] = rd;
         if (!mis && i == 2 + lat && i < a_idx) begin
            mem_ready[u] = 1'b1;
            rd_cap = rd;
         end else if (i == 1 || i >= a_idx) mem_ready[u] = 1'($urandom_range(0, 1));
         else mem_ready[u] = 1'b0;
      end
      @(negedge clk);
      chk("idle_busy", 32'(busy[u]), 32'd0);
      chk("idle_ack", 32'(if_ack[u] | d_ack[u]), 32'd0);
      chk("idle_mem_en", 32'(mem_en[u]), 32'd0);
   endtask

   task automatic drain(input int u);
      for (int k = 0; k < 3 && (if_req[u] || d_req[u]); k++) run_txn(u, -1, 0, 0, 0);
      mem_ready[u] = 0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_busy", 32'(busy[u]), 0);
         chk("rst_mem_en", 32'(mem_en[u]), 0);
         chk("rst_mem_addr", mem_addr[u], 0);
         chk("rst_acks", 32'(if_ack[u] | d_ack[u] | if_err[u] | d_err[u]), 0);
         chk("rst_if_rdata", if_rdata[u], 0);
         chk("rst_d_rdata", d_rdata[u], 0);
         chk("rst_last_grant", 32'(last_grant[u]), 0);
      end

      // zero-wait fetch
      if_req[0] = 1; if_addr[0] = 32'h0000_0100;
      run_txn(0, 0, 0, 1, 32'h0010_0093);
      chk("fetch_word", if_rdata[0], 32'h0010_0093);

      // store word, ready after 4 WAIT cycles
      d_req[0] = 1; d_we[0] = 1; d_size[0] = 2'b10; d_addr[0] = 32'h200; d_wdata[0] = 32'hDEAD_BEEF;
      run_txn(0, 4, 0, 0, 0);

      // fixed-priority tie: data first, then the pending fetch
      new_if(0); if_addr[0][1:0] = 2'b00;
      d_req[0] = 1; d_we[0] = 0; d_size[0] = 2'b10; d_addr[0] = 32'h400;
      run_txn(0, 0, 0, 0, 0);
      chk("tie_data_first", 32'(last_grant[0]), 1);
      run_txn(0, 1, 0, 0, 0);
      chk("tie_fetch_next", 32'(last_grant[0]), 0);

      // round-robin ties alternate D, IF, D, IF
      for (int k = 0; k < 4; k++) begin
         if (!if_req[1]) new_if(1);
         if (!d_req[1]) new_d(1);
         run_txn(1, $urandom_range(0, 3), 0, 0, 0);
         chk("rr_alternate", 32'(last_grant[1]), 32'((k % 2) == 0));
      end
      drain(1);

      // misaligned half load
      d_req[0] = 1; d_we[0] = 0; d_size[0] = 2'b01; d_addr[0] = 32'h203;
      run_txn(0, 0, 0, 0, 0);

      // timeout, then a normal request
      if_req[0] = 1; if_addr[0] = 32'h0000_0800;
      run_txn(0, 40, 0, 0, 0);
      d_req[0] = 1; d_we[0] = 0; d_size[0] = 2'b00; d_addr[0] = 32'h0000_0901;
      run_txn(0, 2, 0, 0, 0);

      for (int n = 0; n < 150; n++) run_txn(0, -1, 1, 0, 0);
      drain(0);
      for (int n = 0; n < 150; n++) run_txn(1, -1, 1, 0, 0);
      drain(1);

      // reset in WAIT abandons the transaction
      d_req[0] = 1; d_we[0] = 0; d_size[0] = 2'b10; d_addr[0] = 32'h300; mem_ready[0] = 0;
      repeat (2) @(negedge clk);
      chk("pre_reset_busy", 32'(busy[0]), 1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy[0]), 0);
      chk("mid_rst_acks", 32'(if_ack[0] | d_ack[0]), 0);
      chk("mid_rst_mem_addr", mem_addr[0], 0);
      chk("mid_rst_rdata", if_rdata[0] | d_rdata[0], 0);
      chk("mid_rst_last_grant", 32'(last_grant[0]), 0);
      reset = 1'b0;
      d_req[0] = 0;
      mem_ready[0] = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("late_ready_ack", 32'(d_ack[0] | if_ack[0]), 0);
         chk("late_ready_mem_en", 32'(mem_en[0]), 0);
         chk("late_ready_busy", 32'(busy[0]), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
